// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings and burst-length helper used by the arbiter and by
// the master/slave agents' sequence items.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Beats remaining after the NONSEQ; undefined-length INCR counts as one.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd3;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd7;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd15;
            default:                      burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration bus bundle: requester-side and arbiter-side views.
interface ahb_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MIDX_W      = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MIDX_W-1:0]      hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first asserted request at or after i_ptr.
module ahb_rr_picker #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MIDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [MIDX_W-1:0]      i_ptr,
    output logic [MIDX_W-1:0]      o_idx,
    output logic                   o_valid
);

    logic [MIDX_W-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            w_cand = MIDX_W'((32'(i_ptr) + k) % NUM_MASTERS);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Burst-aware round-robin AHB arbiter with locked-sequence hold and
// registered grant / address-phase owner outputs.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MIDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic          hclk,
    input  logic          hrst,
    ahb_arbiter_if.slave  bus
);

    logic [4:0]             r_cnt;
    logic [MIDX_W-1:0]      r_rr_ptr;
    logic                   r_locked_hold;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [MIDX_W-1:0]      r_hmaster;
    logic                   r_hmastlock;

    logic                   w_acc_ns;
    logic                   w_acc_seq;
    logic [4:0]             w_cnt_next;
    logic                   w_last;
    logic                   w_arb_pt;
    logic                   w_keep;
    logic                   w_rearb;
    logic [MIDX_W-1:0]      w_gidx;
    logic [MIDX_W-1:0]      w_win;
    logic                   w_valid;
    logic [MIDX_W-1:0]      w_ptr_next;
    logic [NUM_MASTERS-1:0] w_grant_next;

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MIDX_W      (MIDX_W)
    ) u_picker (
        .i_req   (bus.hbusreq),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_win),
        .o_valid (w_valid)
    );

    always_comb begin
        w_gidx = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) w_gidx = MIDX_W'(k);
        end
    end

    always_comb begin
        w_acc_ns  = bus.hready && (bus.htrans == HTRANS_NONSEQ);
        w_acc_seq = bus.hready && (bus.htrans == HTRANS_SEQ);

        w_cnt_next = r_cnt;
        if (w_acc_ns)                        w_cnt_next = burst_beats(bus.hburst);
        else if (w_acc_seq && r_cnt != '0)   w_cnt_next = r_cnt - 5'd1;

        w_last   = (w_acc_ns || w_acc_seq) && (w_cnt_next == '0);
        w_arb_pt = bus.hready && ((bus.htrans == HTRANS_IDLE) || w_last ||
                   ((w_acc_ns || w_acc_seq) && (bus.hburst == HBURST_INCR)));

        // Entering a lock needs the owner to be requesting; once held, only hlock matters.
        w_keep  = r_locked_hold ? bus.hlock[w_gidx]
                                : (bus.hlock[w_gidx] && bus.hbusreq[w_gidx]);
        w_rearb = w_arb_pt && !w_keep;

        w_ptr_next   = (32'(w_win) == NUM_MASTERS - 1) ? '0 : w_win + MIDX_W'(1);
        w_grant_next = NUM_MASTERS'(1);
        if (w_valid) w_grant_next = NUM_MASTERS'(1) << w_win;
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_cnt         <= '0;
            r_rr_ptr      <= '0;
            r_locked_hold <= 1'b0;
            r_grant       <= NUM_MASTERS'(1);
            r_hmaster     <= '0;
            r_hmastlock   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_arb_pt) r_locked_hold <= w_keep;
            if (w_rearb) begin
                r_grant <= w_grant_next;
                if (w_valid) r_rr_ptr <= w_ptr_next;
            end
            if (bus.hready) begin
                r_hmaster   <= w_gidx;
                r_hmastlock <= bus.hlock[w_gidx];
            end
        end
    end

    assign bus.hgrant    = r_grant;
    assign bus.hmaster   = r_hmaster;
    assign bus.hmastlock = r_hmastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset/parking, round-robin, burst hold,
// wait states, locked sequences and reset mid-burst.
module tb_ahb_arbiter;
    import ahb_arb_pkg::*;

    localparam int unsigned NM = 4;

    logic        hclk = 1'b0;
    logic        hrst;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    ahb_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    ahb_arbiter #(.NUM_MASTERS(NM)) dut (
        .hclk (hclk),
        .hrst (hrst),
        .bus  (bus)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lk,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        bus.hbusreq = req;
        bus.hlock   = lk;
        bus.htrans  = tr;
        bus.hburst  = bu;
        bus.hready  = rdy;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
        check("grant_onehot", 32'($countones(bus.hgrant)), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [1:0] m, input logic ml);
        check({tag, "_grant"},   32'(bus.hgrant),    32'(g));
        check({tag, "_hmaster"}, 32'(bus.hmaster),   32'(m));
        check({tag, "_mlock"},   32'(bus.hmastlock), 32'(ml));
    endtask

    initial begin
        // 1: reset and parking on master 0
        hrst = 1'b1;
        drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        step();
        step();
        expect_out("reset", 4'b0001, 2'd0, 1'b0);
        hrst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("park_grant", 32'(bus.hgrant), 32'h1);
        end

        // 2: M1 and M2 request; M1 first (rr_ptr=0), then M2 after M1's SINGLE
        drive(4'b0110, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        step();
        expect_out("rr_m1", 4'b0010, 2'd0, 1'b0);
        drive(4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        step();
        expect_out("rr_m2", 4'b0100, 2'd1, 1'b0);
        drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        step();
        expect_out("rr_park", 4'b0001, 2'd2, 1'b0);

        // 3: M0 INCR4, M3 requests at beat 2; grant moves only with the 4th beat
        step();
        check("b3_hmaster", 32'(bus.hmaster), 32'd0);
        drive(4'b0001, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1);
        step();
        check("b3_beat1", 32'(bus.hgrant), 32'h1);
        for (int i = 2; i <= 3; i++) begin
            drive(4'b1001, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1);
            step();
            check("b3_mid", 32'(bus.hgrant), 32'h1);
        end
        drive(4'b1001, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1);
        step();
        expect_out("b3_last", 4'b1000, 2'd0, 1'b0);

        // 4: same burst with 3 wait states on beat 3
        drive(4'b0001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        step();
        expect_out("b4_regrant", 4'b0001, 2'd3, 1'b0);
        step();
        check("b4_hmaster", 32'(bus.hmaster), 32'd0);
        drive(4'b0001, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1);
        step();
        drive(4'b1001, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1001, 4'b1000, HTRANS_SEQ, HBURST_INCR4, 1'b0);
            step();
            expect_out("b4_wait", 4'b0001, 2'd0, 1'b0);
        end
        drive(4'b1001, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1);
        step();
        check("b4_beat3", 32'(bus.hgrant), 32'h1);
        step();
        expect_out("b4_last", 4'b1000, 2'd0, 1'b0);

        // 5: M1 locked across two INCR8 bursts while M0/M2 request
        drive(4'b0010, 4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        step();
        expect_out("lk_grant", 4'b0010, 2'd3, 1'b0);
        step();
        expect_out("lk_enter", 4'b0010, 2'd1, 1'b1);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) begin
                drive(4'b0111, (b == 1 && i == 7) ? 4'b0000 : 4'b0010,
                      (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR8, 1'b1);
                step();
                if (!(b == 1 && i == 7)) expect_out("lk_hold", 4'b0010, 2'd1, 1'b1);
            end
        end
        expect_out("lk_release", 4'b0100, 2'd1, 1'b0);

        // 6: reset in the middle of an M2 INCR16
        drive(4'b0100, 4'b0100, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        step();
        expect_out("r6_own", 4'b0100, 2'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(4'b0100, 4'b0100, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR16, 1'b1);
            step();
            check("r6_burst", 32'(bus.hgrant), 32'h4);
        end
        hrst = 1'b1;
        drive(4'b0100, 4'b0100, HTRANS_SEQ, HBURST_INCR16, 1'b1);
        step();
        expect_out("r6_reset", 4'b0001, 2'd0, 1'b0);
        hrst = 1'b0;
        drive(4'b1100, 4'b0001, HTRANS_SEQ, HBURST_INCR16, 1'b1);
        step();
        expect_out("r6_regrant", 4'b0100, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter that shares a single slave between NUM_MASTERS masters.
- Issues one-hot hgrant, drives the hmaster select for the address/control mux, and drives hmastlock.
- Burst-aware: a granted fixed-length burst always completes before the grant changes.
- Locked sequences are honoured.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- MIDX_W, $clog2(NUM_MASTERS), width of the master index.

Ports:
- hclk  input  1  bus clock; all logic on the rising edge.
- hrst  input  1  synchronous, active-high reset.
- hbusreq  input  NUM_MASTERS  per-master bus request.
- hlock  input  NUM_MASTERS  per-master lock request.
- htrans  input  2  transfer type of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- hburst  input  3  burst type of the current address-phase owner.
- hready  input  1  slave ready (hready_out from the slave).
- hgrant  output  NUM_MASTERS  one-hot grant, registered.
- hmaster  output  MIDX_W  index of the master owning the address phase, registered.
- hmastlock  output  1  current address-phase owner's transfer is locked, registered.

Behaviour:
- Reset (hrst=1 at a rising edge) forces:
  - hgrant=1 (master 0 parked), hmaster=0, hmastlock=0.
  - beat counter=0, rr_ptr=0, locked_hold=0.
- Beat counter (5 bits):
  - Loads on an accepted NONSEQ (htrans=10, hready=1) with beats-1 for hburst: SINGLE 0; INCR4/WRAP4 3; INCR8/WRAP8 7; INCR16/WRAP16 15; INCR 0 (undefined length).
  - Decrements on each accepted SEQ while nonzero.
  - BUSY and IDLE beats do not change it.
  - A counter value of 0 means the last beat of the burst.
- Arbitration point (arb_pt) requires hready=1 and one of:
  - htrans=IDLE;
  - an accepted NONSEQ/SEQ that is the last beat (counter 0 after load or decrement);
  - the owner is in an INCR burst (any accepted beat).
- Lock hold:
  - locked_hold is set when the granted master has hlock=1 at an arb_pt.
  - While locked_hold=1, no re-arbitration occurs.
  - locked_hold clears at the first arb_pt where that master's hlock=0.
- Selection at an arb_pt (not locked):
  - Search for the first asserted hbusreq starting at index rr_ptr and wrapping modulo NUM_MASTERS.
  - Winner's one-hot value goes into hgrant next cycle; rr_ptr <= winner+1 (wraps to 0).
  - No requests: grant parks on master 0 and rr_ptr is unchanged.
  - If the current owner still requests and wins, hgrant is unchanged.
- Grant to address-phase handover: on any edge with hready=1, hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)]. With hready=0, hmaster and hmastlock hold.
- Latency:
  - hbusreq to hgrant: 1 cycle when the bus is at an arb_pt.
  - hgrant to hmaster: 1 further hready cycle.
- Wait states: hready=0 freezes the counter, hgrant, hmaster and hmastlock.
- Simultaneous events: hbusreq deassert and re-assert in the same cycle as an arb_pt uses the sampled current values only.
- Reset mid-burst: everything returns to reset values on the next edge. No burst completion is attempted.
- hgrant is never zero and never has more than 1 bit set.

Decomposition:
- Shared package ahb_arb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
  - HBURST_SINGLE..WRAP16 constants.
  - Function burst_beats(hburst) returning beats-1.
- Also reused by the master/slave agents' sequence items.
- Sub-module ahb_rr_picker: purely combinational. Inputs req vector and rr_ptr; outputs winner index and a valid flag. Parameterised by NUM_MASTERS.

Test Plan:
1. Reset with hrst=1 for 2 cycles, all hbusreq=0 -> hgrant=0001, hmaster=0, hmastlock=0. With no requests, grant stays parked on master 0 for 10 cycles.
2. Masters 1 and 2 request together, htrans=IDLE, hready=1 -> grant 0010 (M1) next cycle, then hmaster=1. After M1 does a SINGLE NONSEQ and drops hbusreq, grant moves to 0100 (M2).
3. M0 granted in an INCR4 burst (NONSEQ + 3 SEQ); M3 requests at beat 2 -> hgrant stays 0001 until the 4th beat is accepted, then changes to 1000 on the next edge.
4. Same as test 3 with hready=0 for 3 cycles on beat 3 -> counter, hgrant and hmaster frozen. Grant changes only after the final beat is accepted.
5. M1 holds hlock=1 across two INCR8 bursts while M0 and M2 request -> hgrant=0010 and hmastlock=1 throughout. Once hlock drops at an arb_pt, the grant goes to M2 (rr_ptr=2).
6. Assert hrst mid-INCR16 at beat 5 with M2 granted -> next edge gives hgrant=0001, hmaster=0, hmastlock=0, counter=0. M2's re-request is granted 1 cycle after hrst deasserts.
